// File: rtl/image_filter_loader.sv
// Streams a filter block then an image block into two write-only RAM ports,
// launches the indexing pass and waits for it to report completion.
module image_filter_loader #(
    parameter int DATA_W    = 8,
    parameter int FLT_DEPTH = 27,
    parameter int IMG_DEPTH = 27
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Load_start,
    input  logic [DATA_W-1:0] S_DATA,
    input  logic              S_VALID,
    output logic              S_READY,
    output logic [4:0]        FILTER_RAM_WADDR,
    output logic [DATA_W-1:0] FILTER_RAM_WDATA,
    output logic              FILTER_RAM_WE,
    output logic [4:0]        IMAGE_RAM_WADDR,
    output logic [DATA_W-1:0] IMAGE_RAM_WDATA,
    output logic              IMAGE_RAM_WE,
    output logic              Index_start,
    input  logic              Whole_done,
    output logic              Busy,
    output logic              Conv_done
);

    localparam logic [4:0] FLT_LAST = 5'(FLT_DEPTH - 1);
    localparam logic [4:0] IMG_LAST = 5'(IMG_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_FLT,
        LOAD_IMG,
        START,
        WAIT_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [4:0]        cnt_reg, cnt_next;
    logic              hs;
    logic              conv_done_next;

    logic              flt_we_reg, img_we_reg, conv_done_reg;
    logic [4:0]        flt_waddr_reg, img_waddr_reg;
    logic [DATA_W-1:0] flt_wdata_reg, img_wdata_reg;

    assign S_READY     = (state_reg == LOAD_FLT) || (state_reg == LOAD_IMG);
    assign hs          = S_VALID && S_READY;
    assign Busy        = (state_reg != IDLE);
    assign Index_start = (state_reg == START);

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        conv_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (Load_start) begin
                    state_next = LOAD_FLT;
                    cnt_next   = 5'd0;
                end
            end
            LOAD_FLT: begin
                if (hs) begin
                    if (cnt_reg == FLT_LAST) begin
                        state_next = LOAD_IMG;
                        cnt_next   = 5'd0;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
            LOAD_IMG: begin
                if (hs) begin
                    if (cnt_reg == IMG_LAST) begin
                        state_next = START;
                        cnt_next   = 5'd0;
                    end else begin
                        cnt_next = cnt_reg + 5'd1;
                    end
                end
            end
            START: begin
                state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Load_start is deliberately not looked at here: completion wins.
                if (Whole_done) begin
                    state_next     = IDLE;
                    conv_done_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg     <= IDLE;
            cnt_reg       <= 5'd0;
            flt_we_reg    <= 1'b0;
            flt_waddr_reg <= 5'd0;
            flt_wdata_reg <= '0;
            img_we_reg    <= 1'b0;
            img_waddr_reg <= 5'd0;
            img_wdata_reg <= '0;
            conv_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            conv_done_reg <= conv_done_next;
            flt_we_reg    <= hs && (state_reg == LOAD_FLT);
            img_we_reg    <= hs && (state_reg == LOAD_IMG);
            // Address/data only move on an accepted word; WE alone qualifies them.
            if (hs && (state_reg == LOAD_FLT)) begin
                flt_waddr_reg <= cnt_reg;
                flt_wdata_reg <= S_DATA;
            end
            if (hs && (state_reg == LOAD_IMG)) begin
                img_waddr_reg <= cnt_reg;
                img_wdata_reg <= S_DATA;
            end
        end
    end

    assign FILTER_RAM_WE    = flt_we_reg;
    assign FILTER_RAM_WADDR = flt_waddr_reg;
    assign FILTER_RAM_WDATA = flt_wdata_reg;
    assign IMAGE_RAM_WE     = img_we_reg;
    assign IMAGE_RAM_WADDR  = img_waddr_reg;
    assign IMAGE_RAM_WDATA  = img_wdata_reg;
    assign Conv_done        = conv_done_reg;

endmodule

// File: doc/image_filter_loader.md
IMAGE_FILTER_LOADER -- requirements
Module: image_filter_loader

Interface
REQ-001 Parameter DATA_W, default 8: width of one pixel/weight word.
REQ-002 Parameter FLT_DEPTH, default 27: filter words per load (3 ch x 3x3); legal range 1..32.
REQ-003 Parameter IMG_DEPTH, default 27: image words per load; legal range 1..32.
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  asynchronous, active-low reset.
REQ-006 Load_start  input  1  one-cycle request to begin a load; honoured only in IDLE.
REQ-007 S_DATA  input  DATA_W  inbound word stream; filter words first, then image words.
REQ-008 S_VALID  input  1  S_DATA valid.
REQ-009 S_READY  output  1  loader accepts a word this cycle.
REQ-010 FILTER_RAM_WADDR  output  5  filter RAM write address.
REQ-011 FILTER_RAM_WDATA  output  DATA_W  filter RAM write data.
REQ-012 FILTER_RAM_WE  output  1  filter RAM write strobe.
REQ-013 IMAGE_RAM_WADDR  output  5  image RAM write address.
REQ-014 IMAGE_RAM_WDATA  output  DATA_W  image RAM write data.
REQ-015 IMAGE_RAM_WE  output  1  image RAM write strobe.
REQ-016 Index_start  output  1  one-cycle pulse launching the indexing/convolution pass.
REQ-017 Whole_done  input  1  completion from the indexing block.
REQ-018 Busy  output  1  high in every state except IDLE.
REQ-019 Conv_done  output  1  one-cycle pulse when a full load+convolution cycle finishes.

Function
REQ-020 FSM states SHALL be IDLE, LOAD_FLT, LOAD_IMG, START, WAIT_DONE.
REQ-021 IDLE -> LOAD_FLT when Load_start=1; word counter cleared to 0 on the same edge.
REQ-022 S_READY SHALL be combinational: 1 iff state is LOAD_FLT or LOAD_IMG.
REQ-023 Handshake = S_VALID & S_READY; only a handshake advances the word counter; S_VALID low stalls with no write.
REQ-024 Writes registered: a handshake at cycle N yields WE=1, WADDR=counter, WDATA=S_DATA at cycle N+1 on the RAM matching the state at cycle N; WE=0 otherwise.
REQ-025 LOAD_FLT: handshake at counter=FLT_DEPTH-1 -> LOAD_IMG, counter to 0; else counter+1.
REQ-026 LOAD_IMG: handshake at counter=IMG_DEPTH-1 -> START, counter to 0; else counter+1.
REQ-027 Counter 5 bits unsigned; never exceeds DEPTH-1; no wrap past 31.
REQ-028 START: Index_start=1 for exactly this one cycle; next state WAIT_DONE unconditionally.
REQ-029 WAIT_DONE: remain until Whole_done=1; then -> IDLE and Conv_done=1 for one cycle (registered, coincident with first IDLE cycle).
REQ-030 Whole_done outside WAIT_DONE SHALL be ignored; Load_start outside IDLE SHALL be ignored.
REQ-031 Whole_done arriving in the same cycle as entry to WAIT_DONE is honoured next edge (no minimum wait).
REQ-032 Last image write (WE at N+1) SHALL occur in the same cycle as Index_start, so RAM contents are complete before the first indexing read.
REQ-033 Load_start and Whole_done simultaneous in WAIT_DONE: Whole_done wins, Load_start dropped.

Reset
REQ-034 RST=0 SHALL immediately force state IDLE, counter 0, all WE/WADDR/WDATA 0, Index_start 0, Conv_done 0, Busy 0, S_READY 0.
REQ-035 Reset mid-load SHALL abandon the load; no further writes; a new Load_start restarts from filter address 0.
REQ-036 First Load_start honoured on the first rising edge after RST deasserts.

Verification
REQ-037 Full load, S_VALID always 1, defaults: 27 filter writes addr 0..26 then 27 image writes addr 0..26, Index_start pulse 55 cycles after Load_start, S_READY 0 after 54 handshakes.
REQ-038 Stall: S_VALID toggled 1/0 each cycle -> write addresses contiguous, no duplicates, WE only one cycle after each handshake, data matches stream order.
REQ-039 Whole_done held 0 for 100 cycles after Index_start, then 1 -> Busy stays 1 throughout, Conv_done one pulse, state IDLE.
REQ-040 Spurious Load_start during LOAD_IMG and Whole_done during LOAD_FLT -> no effect on counters, writes, or state.
REQ-041 RST low after 10 filter handshakes -> all outputs 0 asynchronously; subsequent Load_start writes filter addr 0 first.
REQ-042 FLT_DEPTH=1, IMG_DEPTH=1 -> one write per RAM at addr 0, Index_start 3 cycles after Load_start.
